// File: rtl/uart_escape_link_pkg.sv
// uart_escape_link_pkg: shared constants and FSM state types for the escaped UART link
package uart_escape_link_pkg;

    localparam logic [7:0] ESC_BYTE_DEFAULT = 8'hE0;

    typedef enum logic {
        RX_IDLE,
        RX_ESC
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ESC,
        TX_BYTE
    } tx_state_t;

endpackage

// File: rtl/uart_escape_link_tx.sv
// uart_escape_link_tx: latches one TAP data/command byte and streams it escaped to the UART transmitter
module uart_escape_link_tx
    import uart_escape_link_pkg::*;
#(
    parameter logic [7:0] ESC_BYTE = ESC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       write,
    input  logic [7:0] data_send,
    input  logic       send_command,
    input  logic [7:0] command,
    output logic       tap_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    tx_state_t  state, state_nxt;
    logic [7:0] payload, payload_nxt;

    // state and latched payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            payload <= '0;
        end else begin
            state   <= state_nxt;
            payload <= payload_nxt;
        end
    end

    // accept a request in idle (command wins), then emit optional escape and the payload
    always_comb begin
        state_nxt   = state;
        payload_nxt = payload;
        tx_valid    = 1'b0;
        tx_data     = '0;
        case (state)
            TX_IDLE: begin
                if (send_command) begin
                    payload_nxt = command;
                    state_nxt   = TX_ESC;
                end else if (write) begin
                    payload_nxt = data_send;
                    state_nxt   = (data_send == ESC_BYTE) ? TX_ESC : TX_BYTE;
                end
            end
            TX_ESC: begin
                tx_valid = 1'b1;
                tx_data  = ESC_BYTE;
                if (tx_ready) state_nxt = TX_BYTE;
            end
            TX_BYTE: begin
                tx_valid = 1'b1;
                tx_data  = payload;
                if (tx_ready) state_nxt = TX_IDLE;
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    assign tap_ready = (state == TX_IDLE);

endmodule

// File: rtl/uart_escape_link.sv
// uart_escape_link: escape-decoding RX holding entry plus escaping TX path between UART and TAP
module uart_escape_link
    import uart_escape_link_pkg::*;
#(
    parameter logic [7:0] ESC_BYTE    = ESC_BYTE_DEFAULT,
    parameter int         ESC_TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       read,
    output logic [7:0] data_rec,
    output logic       rx_empty,
    output logic       cmd_rec,
    input  logic       write,
    input  logic [7:0] data_send,
    input  logic       send_command,
    input  logic [7:0] command,
    output logic       tap_ready,
    output logic       esc_error
);

    localparam int CW = $clog2(ESC_TIMEOUT);

    rx_state_t     rx_state, rx_state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          valid, load, load_cmd, accept;

    assign rx_ready = !valid | read;
    assign rx_empty = !valid;
    assign accept   = rx_valid & rx_ready;

    // RX decoder state and escape timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            cnt      <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            cnt      <= cnt_nxt;
        end
    end

    // decode escape sequences and abandon a dangling escape after the timeout
    always_comb begin
        rx_state_nxt = rx_state;
        cnt_nxt      = cnt;
        esc_error    = 1'b0;
        load         = 1'b0;
        load_cmd     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (accept) begin
                    if (rx_data == ESC_BYTE) begin
                        rx_state_nxt = RX_ESC;
                        cnt_nxt      = '0;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            RX_ESC: begin
                if (accept) begin
                    load         = 1'b1;
                    load_cmd     = (rx_data != ESC_BYTE);
                    rx_state_nxt = RX_IDLE;
                end else if (cnt == CW'(ESC_TIMEOUT - 1)) begin
                    esc_error    = 1'b1;
                    rx_state_nxt = RX_IDLE;
                    cnt_nxt      = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // single holding entry: a new decode overwrites, a read of a full entry empties it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            cmd_rec  <= 1'b0;
            data_rec <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            cmd_rec  <= load_cmd;
            data_rec <= rx_data;
        end else if (read) begin
            valid <= 1'b0;
        end
    end

    uart_escape_link_tx #(
        .ESC_BYTE(ESC_BYTE)
    ) u_tx (
        .clk         (clk),
        .rst_n       (rst_n),
        .write       (write),
        .data_send   (data_send),
        .send_command(send_command),
        .command     (command),
        .tap_ready   (tap_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

endmodule

// File: tb/tb_uart_escape_link.sv
// tb_uart_escape_link: directed stimulus checked every cycle against a queue-based link model
module tb_uart_escape_link;

    localparam int         T   = 16;
    localparam logic [7:0] ESC = 8'hE0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       read = 1'b1;
    logic [7:0] data_rec;
    logic       rx_empty;
    logic       cmd_rec;
    logic       write = 1'b0;
    logic [7:0] data_send = '0;
    logic       send_command = 1'b0;
    logic [7:0] command = '0;
    logic       tap_ready;
    logic       esc_error;

    int errors = 0;
    int checks = 0;
    int bp = 0;

    logic       m_valid = 1'b0;
    logic       m_cmd = 1'b0;
    logic [7:0] m_data = '0;
    int         esc_age = -1;
    logic [7:0] txq[$];

    logic [8:0] rx_log[$];
    logic [7:0] tx_log[$];
    int         err_pulses = 0;

    uart_escape_link #(
        .ESC_BYTE   (ESC),
        .ESC_TIMEOUT(T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .read        (read),
        .data_rec    (data_rec),
        .rx_empty    (rx_empty),
        .cmd_rec     (cmd_rec),
        .write       (write),
        .data_send   (data_send),
        .send_command(send_command),
        .command     (command),
        .tap_ready   (tap_ready),
        .esc_error   (esc_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        tx_ready = (bp == 0) ? 1'b1 : (bp == 1) ? ~tx_ready : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // link model: escape decoding and TX framing written directly from the byte rules
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_cmd   = 1'b0;
            m_data  = '0;
            esc_age = -1;
            txq.delete();
        end else begin
            automatic logic acc = rx_valid && (!m_valid || read);
            if (read) m_valid = 1'b0;
            if (acc) begin
                if (esc_age >= 0) begin
                    m_valid = 1'b1;
                    m_cmd   = (rx_data != ESC);
                    m_data  = rx_data;
                    esc_age = -1;
                end else if (rx_data == ESC) begin
                    esc_age = 0;
                end else begin
                    m_valid = 1'b1;
                    m_cmd   = 1'b0;
                    m_data  = rx_data;
                end
            end else if (esc_age >= 0) begin
                esc_age = (esc_age == T - 1) ? -1 : esc_age + 1;
            end
            if (txq.size() != 0) begin
                if (tx_ready) void'(txq.pop_front());
            end else if (send_command) begin
                txq.push_back(ESC);
                txq.push_back(command);
            end else if (write) begin
                if (data_send == ESC) txq.push_back(ESC);
                txq.push_back(data_send);
            end
        end
    end

    // per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        chk("rx_empty", rx_empty, !m_valid);
        chk("rx_ready", rx_ready, !m_valid || read);
        if (m_valid) begin
            chk("data_rec", data_rec, m_data);
            chk("cmd_rec", cmd_rec, m_cmd);
        end
        chk("esc_error", esc_error, (esc_age == T - 1) && !(rx_valid && (!m_valid || read)));
        chk("tx_valid", tx_valid, txq.size() != 0);
        chk("tap_ready", tap_ready, txq.size() == 0);
        if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
        if (!rx_empty && read) rx_log.push_back({cmd_rec, data_rec});
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (esc_error) err_pulses++;
    end

    task automatic send_raw(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!rx_ready) chk("rx_handshake_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_tap_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!tap_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!tap_ready) chk(name, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic tap_req(input logic is_cmd, input logic [7:0] b);
        if (is_cmd) begin
            send_command = 1'b1;
            command      = b;
        end else begin
            write     = 1'b1;
            data_send = b;
        end
        wait_tap_ready("tap_accept_wait");
        send_command = 1'b0;
        write        = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_cmd_rec", cmd_rec, 0);
        chk("rst_data_rec", data_rec, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tap_ready", tap_ready, 1);
        chk("rst_esc_error", esc_error, 0);
    endtask

    initial begin
        logic [8:0] exp_rx[8];
        logic [7:0] exp_tx[8];
        exp_rx = '{9'h012, 9'h034, 9'h10A, 9'h0E0, 9'h00A, 9'h077, 9'h078, 9'h00A};
        exp_tx = '{8'hE0, 8'h11, 8'hE0, 8'hE0, 8'h55, 8'hE0, 8'h22, 8'h33};
        #2 check_reset_values();
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // plain data back-to-back while a command frame goes out
        fork
            begin
                send_raw(8'h12);
                send_raw(8'h34);
            end
            begin
                tap_req(1'b1, 8'h11);
                wait_tap_ready("tx_frame_done");
            end
        join
        repeat (2) @(posedge clk);
        #1;
        send_raw(ESC);
        send_raw(8'h0A);
        send_raw(ESC);
        send_raw(ESC);
        send_raw(ESC);
        repeat (T + 4) @(posedge clk);
        #1 chk("esc_timeout_pulses", err_pulses, 1);
        send_raw(8'h0A);
        // data escaping under toggling backpressure, then a plain byte
        bp = 1;
        tap_req(1'b0, ESC);
        wait_tap_ready("tx_esc_data_done");
        tap_req(1'b0, 8'h55);
        wait_tap_ready("tx_plain_done");
        bp = 0;
        // coincident requests: command wins, held write goes next
        send_command = 1'b1;
        command      = 8'h22;
        write        = 1'b1;
        data_send    = 8'h33;
        wait_tap_ready("tx_coincident_accept");
        send_command = 1'b0;
        wait_tap_ready("tx_held_write_accept");
        write = 1'b0;
        wait_tap_ready("tx_coincident_done");
        // RX entry held while the TAP does not read
        read = 1'b0;
        send_raw(8'h77);
        fork
            send_raw(8'h78);
            begin
                repeat (3) @(posedge clk);
                #1 read = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        // asynchronous reset mid-escape on both paths
        bp = 2;
        tap_req(1'b1, 8'h5A);
        send_raw(ESC);
        #2;
        chk("pre_rst_tx_valid", tx_valid, 1);
        chk("pre_rst_tx_data", tx_data, ESC);
        rst_n = 1'b0;
        #1 check_reset_values();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 bp = 0;
        send_raw(8'h0A);
        repeat (4) @(posedge clk);
        #1;
        chk("tx_idle_after_rst", tx_valid, 0);
        chk("esc_pulses_total", err_pulses, 1);
        chk("rx_log_len", rx_log.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("rx_entry_%0d", i), (i < rx_log.size()) ? rx_log[i] : 9'h1FF, exp_rx[i]);
        chk("tx_log_len", tx_log.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("tx_byte_%0d", i), (i < tx_log.size()) ? tx_log[i] : 8'hFF, exp_tx[i]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/uart_escape_link.md
Name: uart_escape_link

Overview:
- Byte-level link layer between the raw UART byte transceiver and DMI_UART_TAP.
- RX path: decodes an escaped byte stream into one-entry "data or command" records, exposed as DATA_REC/CMD_REC/RX_EMPTY/READ.
- TX path: accepts data bytes and command bytes from the TAP, escapes them, and streams them to the UART transmitter over valid/ready.
- Escape rule: ESC,ESC = literal data byte ESC; ESC,X (X≠ESC) = command byte X; any other byte = data.

Parameters:
- ESC_BYTE, 8'hE0, escape marker value.
- ESC_TIMEOUT, 100000, cycles allowed between ESC and its follow-up byte before the escape is abandoned; must be ≥2.

Ports:
- CLK_I  in  1  clock.
- RST_NI  in  1  reset, asynchronous, active-low.
- RX_DATA_I  in  8  raw byte from UART receiver.
- RX_VALID_I  in  1  raw byte valid.
- RX_READY_O  out  1  raw byte accepted when RX_VALID_I & RX_READY_O.
- TX_DATA_O  out  8  raw byte to UART transmitter.
- TX_VALID_O  out  1  raw byte valid.
- TX_READY_I  in  1  transmitter accepts when TX_VALID_O & TX_READY_I.
- READ_I  in  1  TAP consumes the current RX entry.
- DATA_REC_O  out  8  current RX entry payload.
- RX_EMPTY_O  out  1  no RX entry held.
- CMD_REC_O  out  1  current entry is a command.
- WRITE_I  in  1  TAP requests sending data byte DATA_SEND_I.
- DATA_SEND_I  in  8  data byte.
- SEND_COMMAND_I  in  1  TAP requests sending command byte COMMAND_I.
- COMMAND_I  in  8  command byte.
- TX_READY_O  out  1  TX path idle; request accepted this cycle.
- ESC_ERROR_O  out  1  one-cycle pulse on escape timeout.

Behaviour:

Reset:
- RX_READY_O=1, RX_EMPTY_O=1, CMD_REC_O=0, DATA_REC_O=0, TX_VALID_O=0, TX_DATA_O=0, TX_READY_O=1, ESC_ERROR_O=0.
- FSMs go to IDLE and the timeout counter clears, including mid-frame. A partial ESC sequence is discarded.

RX holding entry:
- Single register {valid, cmd, data}. RX_EMPTY_O=!valid.
- READ_I with valid=1 clears the entry next cycle. READ_I while empty is ignored.
- RX_READY_O = !valid | READ_I, combinational. A raw byte can be accepted the same cycle the entry is consumed, giving back-to-back throughput.

RX FSM (RX_IDLE, RX_ESC):
- RX_IDLE, byte≠ESC: entry ← {1,0,byte}.
- RX_IDLE, byte=ESC: go to RX_ESC; no entry; counter cleared.
- RX_ESC, byte=ESC: entry ← {1,0,ESC}; go to RX_IDLE.
- RX_ESC, byte≠ESC: entry ← {1,1,byte}; go to RX_IDLE.
- RX_ESC with no accepted byte: counter increments. When it reaches ESC_TIMEOUT-1, pulse ESC_ERROR_O, return to RX_IDLE, clear counter.
- Decoded entry is visible 1 cycle after the raw handshake.

TX FSM (TX_IDLE, TX_ESC, TX_BYTE):
- TX_READY_O is registered and high only in TX_IDLE.
- Accept on TX_READY_O & (SEND_COMMAND_I | WRITE_I). SEND_COMMAND_I has priority; a coincident WRITE_I is not accepted and must be held by the TAP.
- On accept, latch the byte. TX_READY_O falls the next cycle.
- Command, or data equal to ESC_BYTE: emit ESC (state TX_ESC), then emit the payload (state TX_BYTE).
- Other data: emit the payload only (TX_BYTE).
- Each emitted byte: TX_VALID_O held with stable TX_DATA_O until TX_READY_I. Advance on handshake.
- After the final handshake, return to TX_IDLE; TX_READY_O rises the following cycle.
- Requests while TX_READY_O=0 are ignored. TAP write strobes that stay asserted after accept are never double-sent.

RX and TX are fully independent; simultaneous activity is required.

Decomposition:
- uart_pkg gets: ESC_BYTE_DEFAULT constant, rx_state_t and tx_state_t enums.
- Natural split: sub-module uart_escape_tx (TX FSM + latch, about 100 lines). RX path stays in the top.

Test Plan:
1. Raw 8'h12, 8'h34 → two entries, DATA_REC_O=12 then 34, CMD_REC_O=0; with READ_I asserted every cycle, the raw side stays ready back-to-back.
2. Raw E0,0A then E0,E0 → entry {cmd=1,0A}, then entry {cmd=0,E0}; no entry is produced for either E0 prefix.
3. Raw E0, then idle for ESC_TIMEOUT=16 cycles → ESC_ERROR_O pulses once; next raw 8'h0A decodes as data.
4. SEND_COMMAND_I with COMMAND_I=8'h11, TX_READY_I=1 → TX emits E0 then 11; TX_READY_O low for the frame, high again 1 cycle after the last handshake.
5. WRITE_I with DATA_SEND_I=E0, TX_READY_I toggling 0/1 → TX emits E0,E0 with stable data under backpressure. Then DATA_SEND_I=55 → single byte 55.
6. RST_NI pulsed low mid-TX_ESC and mid-RX_ESC → all outputs return to reset values asynchronously; next raw 8'h0A yields a data entry.
